// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-master round-robin arbiter and sequencer for the single-port data SRAM
module sram_arbiter #(
    parameter int A_BITS  = 10,
    parameter int D_BITS  = 16,
    parameter int MEMSIZE = 1023
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [A_BITS-1:0] m0_addr,
    input  logic [D_BITS-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [D_BITS-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [A_BITS-1:0] m1_addr,
    input  logic [D_BITS-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [D_BITS-1:0] m1_rdata,
    output logic [A_BITS-1:0] sram_address,
    output logic [D_BITS-1:0] sram_data_out,
    output logic              sram_read,
    output logic              sram_write,
    input  logic [D_BITS-1:0] sram_data_in,
    output logic              owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t state;
    logic   last_grant;
    logic   we_q;
    logic   oor_q;

    logic              winner;
    logic              sel_we;
    logic [A_BITS-1:0] sel_addr;
    logic [D_BITS-1:0] sel_wdata;
    logic              sel_oor;

    // Pick the winner: a lone requester wins, a tie goes to the master not granted last.
    always_comb begin
        winner    = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (m0_req && m1_req) begin
            winner = ~last_grant;
        end else begin
            winner = m1_req;
        end
        if (winner) begin
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end else begin
            sel_we    = m0_we;
            sel_addr  = m0_addr;
            sel_wdata = m0_wdata;
        end
        sel_oor = (32'(sel_addr) >= MEMSIZE);
    end

    // IDLE -> ISSUE -> RESP sequencer; SRAM strobes are registered at the sampling edge
    // so that later changes on the request fields cannot reach the SRAM.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            busy          <= 1'b0;
            we_q          <= 1'b0;
            oor_q         <= 1'b0;
            sram_address  <= '0;
            sram_data_out <= '0;
            sram_read     <= 1'b0;
            sram_write    <= 1'b0;
            m0_ack        <= 1'b0;
            m0_err        <= 1'b0;
            m1_ack        <= 1'b0;
            m1_err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        state         <= ISSUE;
                        owner         <= winner;
                        last_grant    <= winner;
                        busy          <= 1'b1;
                        we_q          <= sel_we;
                        oor_q         <= sel_oor;
                        sram_address  <= sel_addr;
                        sram_data_out <= sel_wdata;
                        sram_write    <= sel_we & ~sel_oor;
                        sram_read     <= ~sel_we & ~sel_oor;
                    end
                end
                ISSUE: begin
                    state         <= RESP;
                    sram_address  <= '0;
                    sram_data_out <= '0;
                    sram_read     <= 1'b0;
                    sram_write    <= 1'b0;
                    m0_ack        <= ~owner;
                    m1_ack        <= owner;
                    m0_err        <= ~owner & oor_q;
                    m1_err        <= owner & oor_q;
                end
                RESP: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    m0_err <= 1'b0;
                    m1_err <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read data passes straight through from the SRAM in the owner's ack cycle only.
    assign m0_rdata = (m0_ack && !we_q && !oor_q) ? sram_data_in : '0;
    assign m1_rdata = (m1_ack && !we_q && !oor_q) ? sram_data_in : '0;

endmodule
